// File: rtl/weight_load_ctrl_pkg.sv
// rtl/weight_load_ctrl_pkg.sv - shared types and helpers for the weight load sequencer
//
// Purpose: sequencer state encoding and a ceiling-division helper used to turn
// element counts into bus-word counts.
// Ports: none (package).

package weight_load_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_FETCH,
        B_FETCH,
        DRAIN,
        TRIG,
        WAIT_LD,
        ABORT_DRAIN
    } state_t;

    // Number of d-element words needed to hold n elements.
    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/rd_issue_tracker.sv
// rtl/rd_issue_tracker.sv - read request issue index, address and outstanding throttle
//
// Purpose: generates base+index read addresses, advances the index on each
// accepted request and tracks accepted-but-unreturned reads, holding off new
// requests once MAX_OUTSTANDING are in flight.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr           zero the issue index (new fetch phase)
//   issue_en      fetch phase wants to issue
//   base          word address of index 0
//   gnt           memory accepted the request this cycle
//   rd_valid      a return beat arrived
//   req, addr     request strobe and word address
//   grant         req && gnt
//   issue_idx     requests accepted in the current phase
//   outstanding   accepted requests not yet returned

module rd_issue_tracker #(
    parameter int ADDR_WIDTH      = 32,
    parameter int IDX_WIDTH       = 7,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic                  gnt,
    input  logic                  rd_valid,
    output logic                  req,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  grant,
    output logic [IDX_WIDTH-1:0]  issue_idx,
    output logic [OUT_WIDTH-1:0]  outstanding
);

    logic ret_dec;

    assign req     = issue_en && (outstanding < OUT_WIDTH'(MAX_OUTSTANDING));
    assign grant   = req && gnt;
    // Natural modulo-2^ADDR_WIDTH wrap past the top of the address space.
    assign addr    = base + ADDR_WIDTH'(issue_idx);
    // Guard against a stray beat driving the counter below zero.
    assign ret_dec = rd_valid && (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_idx <= '0;
        end else if (clr) begin
            issue_idx <= '0;
        end else if (grant) begin
            issue_idx <= issue_idx + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (grant && !ret_dec) begin
            outstanding <= outstanding + OUT_WIDTH'(1);
        end else if (ret_dec && !grant) begin
            outstanding <= outstanding - OUT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - fetches one tile of weights and biases into weight_loader
//
// Purpose: on start, reads ceil(R*C/EPW) weight words then ceil(C/EPW) bias
// words through a pipelined in-order memory port, writes each returned beat
// into the loader, triggers the loader and waits for its completion. Abort
// drains outstanding reads without writing.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   start, abort                       command inputs
//   cfg_*                              tile configuration, latched at start
//   mem_rd_req/addr/gnt/valid/data     shared memory read port
//   weight_data_out/wr_addr/wr_en      loader weight write port
//   bias_data_out/wr_addr/wr_en        loader bias write port
//   valid_row_num, valid_col_num       latched tile size for the loader
//   load_weight_trigger, weight_loading_done  loader handshake
//   busy, done, aborted                status

module weight_load_ctrl
    import weight_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int SIZE            = 16,
    parameter int BUS_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         cfg_weight_base,
    input  logic [ADDR_WIDTH-1:0]         cfg_bias_base,
    input  logic [$clog2(SIZE)-1:0]       cfg_row_num,
    input  logic [$clog2(SIZE)-1:0]       cfg_col_num,
    output logic                          mem_rd_req,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic                          mem_rd_gnt,
    input  logic                          mem_rd_valid,
    input  logic [BUS_WIDTH-1:0]          mem_rd_data,
    output logic [BUS_WIDTH-1:0]          weight_data_out,
    output logic [$clog2(SIZE*SIZE)-1:0]  weight_wr_addr,
    output logic                          weight_wr_en,
    output logic [BUS_WIDTH-1:0]          bias_data_out,
    output logic [$clog2(SIZE)-1:0]       bias_wr_addr,
    output logic                          bias_wr_en,
    output logic [$clog2(SIZE)-1:0]       valid_row_num,
    output logic [$clog2(SIZE)-1:0]       valid_col_num,
    output logic                          load_weight_trigger,
    input  logic                          weight_loading_done,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted
);

    localparam int unsigned EPW = BUS_WIDTH / DATA_WIDTH;
    localparam int CNT_W = $clog2(SIZE * SIZE + SIZE + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WA_W  = $clog2(SIZE * SIZE);
    localparam int BA_W  = $clog2(SIZE);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] wbase_q, bbase_q, fetch_base;
    logic [CNT_W-1:0]      w_words, b_words, w_words_new, b_words_new;
    logic [CNT_W-1:0]      ret_cnt, issue_idx;
    logic [OUT_W-1:0]      outstanding;
    logic                  issue_en, idx_clr, grant, start_acc;
    logic                  fetching, count_beat, route_beat, beat_is_weight;

    assign w_words_new = CNT_W'(ceil_div((32'(cfg_row_num) + 32'd1) * (32'(cfg_col_num) + 32'd1), EPW));
    assign b_words_new = CNT_W'(ceil_div(32'(cfg_col_num) + 32'd1, EPW));

    assign fetching   = (state == W_FETCH) || (state == B_FETCH) || (state == DRAIN);
    // Returns are counted while draining after abort, but never written.
    assign count_beat = mem_rd_valid && (fetching || (state == ABORT_DRAIN));
    // A beat landing in the abort cycle is dropped so nothing is written after abort.
    assign route_beat     = mem_rd_valid && fetching && !abort;
    assign beat_is_weight = ret_cnt < w_words;
    assign fetch_base     = (state == B_FETCH) ? bbase_q : wbase_q;
    assign busy           = (state != IDLE);

    rd_issue_tracker #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .IDX_WIDTH       (CNT_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .OUT_WIDTH       (OUT_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (idx_clr),
        .issue_en    (issue_en),
        .base        (fetch_base),
        .gnt         (mem_rd_gnt),
        .rd_valid    (mem_rd_valid),
        .req         (mem_rd_req),
        .addr        (mem_rd_addr),
        .grant       (grant),
        .issue_idx   (issue_idx),
        .outstanding (outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wbase_q       <= '0;
            bbase_q       <= '0;
            w_words       <= '0;
            b_words       <= '0;
            valid_row_num <= '0;
            valid_col_num <= '0;
            ret_cnt       <= '0;
        end else begin
            state <= state_n;
            if (start_acc) begin
                wbase_q       <= cfg_weight_base;
                bbase_q       <= cfg_bias_base;
                w_words       <= w_words_new;
                b_words       <= b_words_new;
                valid_row_num <= cfg_row_num;
                valid_col_num <= cfg_col_num;
                ret_cnt       <= '0;
            end else if (count_beat) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

    // Loader write ports: one cycle behind the return beat; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_wr_en    <= 1'b0;
            weight_wr_addr  <= '0;
            weight_data_out <= '0;
            bias_wr_en      <= 1'b0;
            bias_wr_addr    <= '0;
            bias_data_out   <= '0;
        end else begin
            weight_wr_en <= route_beat && beat_is_weight;
            bias_wr_en   <= route_beat && !beat_is_weight;
            if (route_beat && beat_is_weight) begin
                weight_wr_addr  <= WA_W'(ret_cnt);
                weight_data_out <= mem_rd_data;
            end
            if (route_beat && !beat_is_weight) begin
                bias_wr_addr  <= BA_W'(ret_cnt - w_words);
                bias_data_out <= mem_rd_data;
            end
        end
    end

    always_comb begin
        state_n             = state;
        issue_en            = 1'b0;
        idx_clr             = 1'b0;
        start_acc           = 1'b0;
        load_weight_trigger = 1'b0;
        done                = 1'b0;
        aborted             = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    idx_clr   = 1'b1;
                    state_n   = W_FETCH;
                end
            end
            W_FETCH: begin
                issue_en = 1'b1;
                if (abort) begin
                    state_n = ABORT_DRAIN;
                end else if (grant && (issue_idx == w_words - CNT_W'(1))) begin
                    idx_clr = 1'b1;
                    state_n = B_FETCH;
                end
            end
            B_FETCH: begin
                issue_en = 1'b1;
                if (abort) begin
                    state_n = ABORT_DRAIN;
                end else if (grant && (issue_idx == b_words - CNT_W'(1))) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // ret_cnt reaches the total on the same edge the last write is registered.
                if (abort) begin
                    state_n = ABORT_DRAIN;
                end else if (ret_cnt == w_words + b_words) begin
                    state_n = TRIG;
                end
            end
            TRIG: begin
                load_weight_trigger = 1'b1;
                state_n             = WAIT_LD;
            end
            WAIT_LD: begin
                if (weight_loading_done) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (abort) begin
                    aborted = 1'b1;
                    state_n = IDLE;
                end
            end
            ABORT_DRAIN: begin
                if (outstanding == '0) begin
                    aborted = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - scoreboard bench for weight_load_ctrl

module tb_weight_load_ctrl;

    localparam int MO  = 4;
    localparam int EPW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [31:0] cfg_weight_base, cfg_bias_base;
    logic [3:0]  cfg_row_num, cfg_col_num;
    logic        mem_rd_req, mem_rd_gnt, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic [31:0] weight_data_out, bias_data_out;
    logic [7:0]  weight_wr_addr;
    logic [3:0]  bias_wr_addr;
    logic        weight_wr_en, bias_wr_en;
    logic [3:0]  valid_row_num, valid_col_num;
    logic        load_weight_trigger, weight_loading_done;
    logic        busy, done, aborted;

    weight_load_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .cfg_weight_base     (cfg_weight_base),
        .cfg_bias_base       (cfg_bias_base),
        .cfg_row_num         (cfg_row_num),
        .cfg_col_num         (cfg_col_num),
        .mem_rd_req          (mem_rd_req),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_gnt          (mem_rd_gnt),
        .mem_rd_valid        (mem_rd_valid),
        .mem_rd_data         (mem_rd_data),
        .weight_data_out     (weight_data_out),
        .weight_wr_addr      (weight_wr_addr),
        .weight_wr_en        (weight_wr_en),
        .bias_data_out       (bias_data_out),
        .bias_wr_addr        (bias_wr_addr),
        .bias_wr_en          (bias_wr_en),
        .valid_row_num       (valid_row_num),
        .valid_col_num       (valid_col_num),
        .load_weight_trigger (load_weight_trigger),
        .weight_loading_done (weight_loading_done),
        .busy                (busy),
        .done                (done),
        .aborted             (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_bias;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] exp_req_q[$];
    wr_t         exp_wr_q[$];
    logic [31:0] infl_addr[$];
    int          infl_due[$];

    int checks = 0, errs = 0;
    int cyc = 0, tb_out = 0, lat = 3, gnt_pct = 100, ld_delay = -1;
    bit hold_ret = 0, ld_hold = 0;
    int trig_cnt = 0, done_cnt = 0, abort_cnt = 0, load_grants = 0;
    int last_valid_cyc = 0, aborted_cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_write(input bit is_bias, input int addr, input logic [31:0] data);
        wr_t e;
        if (exp_wr_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_write: bias=%0d addr=%0d data=%0h, required no write", is_bias, addr, data);
        end else begin
            e = exp_wr_q.pop_front();
            chk("wr_kind", 64'(is_bias), 64'(e.is_bias));
            chk("wr_addr", 64'(addr), 64'(e.addr));
            chk("wr_data", data, e.data);
        end
    endtask

    // Monitor: samples DUT outputs mid-cycle and pops the scoreboard.
    always @(negedge clk) begin
        if (weight_wr_en) check_write(1'b0, int'(weight_wr_addr), weight_data_out);
        if (bias_wr_en)   check_write(1'b1, int'(bias_wr_addr), bias_data_out);
        if (load_weight_trigger) begin
            trig_cnt++;
            chk("trig_all_written", 64'(exp_wr_q.size()), 0);
            ld_delay = $urandom_range(1, 5);
        end
        if (done) begin
            done_cnt++;
            chk("done_all_written", 64'(exp_wr_q.size()), 0);
            chk("done_after_one_trig", 64'(trig_cnt), 1);
        end
        if (aborted) begin
            abort_cnt++;
            aborted_cyc = cyc;
        end
        if (mem_rd_req) chk("outstanding_cap", 64'((tb_out + int'(mem_rd_valid)) < MO), 1);
        if (mem_rd_req && mem_rd_gnt) begin
            load_grants++;
            if (exp_req_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL req_addr: got %0h, required no request", mem_rd_addr);
            end else begin
                chk("req_addr", mem_rd_addr, exp_req_q.pop_front());
            end
            infl_addr.push_back(mem_rd_addr);
            infl_due.push_back(cyc + lat);
            tb_out++;
        end
    end

    // Memory and loader model: drives inputs just after each rising edge.
    always @(posedge clk) begin : drv
        logic [31:0] a;
        #1;
        cyc++;
        mem_rd_valid = 1'b0;
        if (!hold_ret && infl_addr.size() > 0 && infl_due[0] <= cyc) begin
            a = infl_addr.pop_front();
            void'(infl_due.pop_front());
            mem_rd_valid   = 1'b1;
            mem_rd_data    = mem_word(a);
            tb_out--;
            last_valid_cyc = cyc;
        end
        mem_rd_gnt = ($urandom_range(1, 100) <= gnt_pct);
        weight_loading_done = 1'b0;
        if (ld_delay > 0) begin
            ld_delay--;
            if (ld_delay == 0 && !ld_hold) weight_loading_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_load(input logic [31:0] wb, input logic [31:0] bb, input int r, input int c);
        int nw, nb;
        nw = ((r + 1) * (c + 1) + EPW - 1) / EPW;
        nb = (c + 1 + EPW - 1) / EPW;
        trig_cnt    = 0;
        load_grants = 0;
        for (int i = 0; i < nw; i++) begin
            exp_req_q.push_back(wb + 32'(i));
            exp_wr_q.push_back('{is_bias: 1'b0, addr: i, data: mem_word(wb + 32'(i))});
        end
        for (int j = 0; j < nb; j++) begin
            exp_req_q.push_back(bb + 32'(j));
            exp_wr_q.push_back('{is_bias: 1'b1, addr: j, data: mem_word(bb + 32'(j))});
        end
        cfg_weight_base = wb;
        cfg_bias_base   = bb;
        cfg_row_num     = 4'(r);
        cfg_col_num     = 4'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Later config changes must not affect the running load.
        cfg_weight_base = $urandom;
        cfg_bias_base   = $urandom;
        cfg_row_num     = 4'($urandom);
        cfg_col_num     = 4'($urandom);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 4000 && done_cnt == d0; i++) tick();
        chk("done_seen", 64'(done_cnt > d0), 1);
    endtask

    task automatic run_load(input logic [31:0] wb, input logic [31:0] bb, input int r, input int c, input bit poke);
        int d0;
        d0 = done_cnt;
        start_load(wb, bb, r, c);
        if (poke) begin
            repeat (3) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(d0);
        tick();
        chk("busy_after_done", 64'(busy), 0);
        chk("valid_row_num", 64'(valid_row_num), 64'(r));
        chk("valid_col_num", 64'(valid_col_num), 64'(c));
        chk("trig_once", 64'(trig_cnt), 1);
        chk("all_reqs_issued", 64'(exp_req_q.size()), 0);
    endtask

    initial begin
        int a0, d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_weight_base = '0;
        cfg_bias_base   = '0;
        cfg_row_num     = '0;
        cfg_col_num     = '0;
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;
        weight_loading_done = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        chk("rst_busy", 64'(busy), 0);
        chk("rst_req", 64'(mem_rd_req), 0);
        chk("rst_wr_en", 64'({weight_wr_en, bias_wr_en}), 0);
        chk("rst_flags", 64'({load_weight_trigger, done, aborted}), 0);
        chk("rst_valid_rc", 64'({valid_row_num, valid_col_num}), 0);

        // Full 16x16 tile, always granted, fixed latency.
        gnt_pct = 100;
        lat = 3;
        run_load(32'h0000_1000, 32'h0000_2000, 15, 15, 1'b0);

        // 3x5 tile with a start pulse while busy.
        run_load(32'h4000_0010, 32'h4000_0100, 2, 4, 1'b1);

        // Weight base at top of address space wraps to 0.
        run_load(32'hFFFF_FFFE, 32'h0000_0008, 2, 4, 1'b0);

        // Returns stalled: requests throttle at MAX_OUTSTANDING.
        hold_ret = 1'b1;
        d0 = done_cnt;
        start_load(32'h0000_3000, 32'h0000_3800, 15, 15);
        repeat (10) tick();
        chk("stall_grants", 64'(load_grants), 4);
        chk("stall_req_low", 64'(mem_rd_req), 0);
        hold_ret = 1'b0;
        wait_done(d0);
        tick();
        chk("stall_busy_after", 64'(busy), 0);

        // Abort with three reads outstanding.
        hold_ret = 1'b1;
        lat = 1;
        a0 = abort_cnt;
        start_load(32'h0000_9000, 32'h0000_A000, 15, 15);
        for (int i = 0; i < 50 && tb_out < 2; i++) tick();
        gnt_pct = 0;
        for (int i = 0; i < 50 && tb_out < 3; i++) tick();
        repeat (3) tick();
        chk("abort_outstanding", 64'(tb_out), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_req_q.delete();
        exp_wr_q.delete();
        hold_ret = 1'b0;
        for (int i = 0; i < 50 && abort_cnt == a0; i++) tick();
        chk("abort_pulse", 64'(abort_cnt), 64'(a0 + 1));
        chk("abort_latency", 64'(aborted_cyc), 64'(last_valid_cyc + 1));
        chk("abort_no_trig", 64'(trig_cnt), 0);
        chk("abort_busy", 64'(busy), 0);
        gnt_pct = 100;
        lat = 3;

        // Abort while waiting on the loader.
        ld_hold = 1'b1;
        a0 = abort_cnt;
        d0 = done_cnt;
        start_load(32'h0000_0040, 32'h0000_0080, 1, 1);
        for (int i = 0; i < 200 && trig_cnt == 0; i++) tick();
        repeat (2) tick();
        chk("wait_ld_busy", 64'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wait_ld_aborted", 64'(abort_cnt), 64'(a0 + 1));
        chk("wait_ld_no_done", 64'(done_cnt), 64'(d0));
        chk("wait_ld_idle", 64'(busy), 0);
        ld_hold = 1'b0;
        ld_delay = -1;

        // Asynchronous reset during bias fetch, then a clean full load.
        start_load(32'h0000_0300, 32'h0000_0500, 15, 15);
        for (int i = 0; i < 2000 && load_grants < 66; i++) tick();
        chk("reached_bias_fetch", 64'(load_grants >= 66), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy_req", 64'({busy, mem_rd_req}), 0);
        chk("arst_wr", 64'({weight_wr_en, bias_wr_en, weight_wr_addr, bias_wr_addr}), 0);
        chk("arst_data", {weight_data_out, bias_data_out}, 0);
        chk("arst_flags", 64'({load_weight_trigger, done, aborted, valid_row_num, valid_col_num}), 0);
        chk("arst_addr", 64'(mem_rd_addr), 0);
        exp_req_q.delete();
        exp_wr_q.delete();
        infl_addr.delete();
        infl_due.delete();
        tb_out = 0;
        mem_rd_valid = 1'b0;
        ld_delay = -1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_load(32'h0000_0700, 32'h0000_0900, 15, 15, 1'b0);

        // Randomised tiles, grant rates and latencies.
        for (int n = 0; n < 6; n++) begin
            gnt_pct = $urandom_range(30, 100);
            lat = $urandom_range(1, 6);
            run_load($urandom, $urandom, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
